// File: rtl/dsub_serial.sv
// dsub_serial: nibble-serial packed-BCD subtractor (dst - src - ~Cin), one digit per MCLK.
// Optional non-BCD digit detection is built when DSUB_INVALID_DIGIT_EN is defined.
module dsub_serial (
  input  logic        MCLK,
  input  logic        RSTn,
  input  logic        start,
  input  logic        bw,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic        Cin,
  output logic [15:0] result,
  output logic        Cout,
  output logic        Vout,
  output logic        Nout,
  output logic        Zout,
  output logic        busy,
  output logic        done,
  output logic        bad,
  output logic [1:0]  dbg_state
);

  // Handshake: start is accepted on a rising edge whenever busy=0 (IDLE or DONE);
  // done is high for exactly the one cycle in which result and flags first show the new value.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic        bw_q, bw_d;
  logic        borrow_q, borrow_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic        nout_q, nout_d;
  logic        zout_q, zout_d;

  logic [15:0] dst_sh, src_sh;
  logic [3:0]  d_nib, s_nib;
  logic [4:0]  diff, diff_adj;
  logic        neg;
  logic [3:0]  digit;
  logic [15:0] acc_upd;
  logic [15:0] res_act;
  logic        last;
  logic        accept;

  assign dst_sh   = dst_q >> {idx_q, 2'b00};
  assign src_sh   = src_q >> {idx_q, 2'b00};
  assign d_nib    = dst_sh[3:0];
  assign s_nib    = src_sh[3:0];
  // 5-bit two's complement difference; bit 4 set means the digit went negative.
  assign diff     = {1'b0, d_nib} - {1'b0, s_nib} - {4'b0000, borrow_q};
  assign diff_adj = diff + 5'd10;
  assign neg      = diff[4];
  assign digit    = neg ? diff_adj[3:0] : diff[3:0];
  assign last     = bw_q ? (idx_q == 2'd1) : (idx_q == 2'd3);
  assign res_act  = bw_q ? {8'h00, acc_upd[7:0]} : acc_upd;
  assign accept   = start && (state_q != S_RUN);

  always_comb begin
    acc_upd = acc_q;
    acc_upd[{idx_q, 2'b00} +: 4] = digit;
  end

`ifdef DSUB_INVALID_DIGIT_EN
  logic hit;
  logic sticky_q, sticky_d;
  logic bad_q, bad_d;
  assign hit = (d_nib > 4'd9) || (s_nib > 4'd9);
  assign bad = bad_q;
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    bw_d     = bw_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    nout_d   = nout_q;
    zout_d   = zout_q;
`ifdef DSUB_INVALID_DIGIT_EN
    sticky_d = sticky_q;
    bad_d    = bad_q;
`endif
    case (state_q)
      S_RUN: begin
        acc_d    = acc_upd;
        borrow_d = neg;
        idx_d    = idx_q + 2'd1;
`ifdef DSUB_INVALID_DIGIT_EN
        sticky_d = sticky_q | hit;
`endif
        if (last) begin
          state_d  = S_DONE;
          result_d = res_act;
          cout_d   = ~neg;
          nout_d   = bw_q ? res_act[7] : res_act[15];
          zout_d   = (res_act == 16'h0000);
`ifdef DSUB_INVALID_DIGIT_EN
          bad_d    = sticky_q | hit;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Accept overrides the DONE->IDLE return so back-to-back starts lose no cycle.
    if (accept) begin
      state_d  = S_RUN;
      src_d    = src;
      dst_d    = dst;
      bw_d     = bw;
      borrow_d = ~Cin;
      idx_d    = 2'd0;
      acc_d    = 16'h0000;
`ifdef DSUB_INVALID_DIGIT_EN
      sticky_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge MCLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      src_q    <= 16'h0000;
      dst_q    <= 16'h0000;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      idx_q    <= 2'd0;
      acc_q    <= 16'h0000;
      result_q <= 16'h0000;
      cout_q   <= 1'b0;
      nout_q   <= 1'b0;
      zout_q   <= 1'b0;
`ifdef DSUB_INVALID_DIGIT_EN
      sticky_q <= 1'b0;
      bad_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      bw_q     <= bw_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      nout_q   <= nout_d;
      zout_q   <= zout_d;
`ifdef DSUB_INVALID_DIGIT_EN
      sticky_q <= sticky_d;
      bad_q    <= bad_d;
`endif
    end
  end

  assign result    = result_q;
  assign Cout      = cout_q;
  assign Vout      = 1'b0;
  assign Nout      = nout_q;
  assign Zout      = zout_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dsub_serial.sv
// Directed bench for dsub_serial: hand-computed BCD differences, flags, latency and abort.
module tb_dsub_serial;

  logic        MCLK;
  logic        RSTn;
  logic        start;
  logic        bw;
  logic [15:0] src;
  logic [15:0] dst;
  logic        Cin;
  logic [15:0] result;
  logic        Cout, Vout, Nout, Zout, busy, done, bad;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int lat;
  logic got;
  logic busy_seen;
  logic done_seen;
  logic exp_bad;

  dsub_serial dut (
    .MCLK(MCLK), .RSTn(RSTn), .start(start), .bw(bw), .src(src), .dst(dst), .Cin(Cin),
    .result(result), .Cout(Cout), .Vout(Vout), .Nout(Nout), .Zout(Zout),
    .busy(busy), .done(done), .bad(bad), .dbg_state(dbg_state)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic c, input logic n, input logic z);
    check({tag, ".C"}, {15'd0, Cout}, {15'd0, c});
    check({tag, ".N"}, {15'd0, Nout}, {15'd0, n});
    check({tag, ".Z"}, {15'd0, Zout}, {15'd0, z});
    check({tag, ".V"}, {15'd0, Vout}, 16'd0);
  endtask

  // Issue one operation from a negedge and wait (bounded) for done; lat counts negedges.
  task automatic run_op(input logic [15:0] d, input logic [15:0] s, input logic c,
                        input logic b, input bit inject);
    dst = d; src = s; Cin = c; bw = b; start = 1'b1;
    @(negedge MCLK);
    start = 1'b0; lat = 1; busy_seen = busy; got = done;
    while (!got && lat < 12) begin
      if (inject && lat == 2) begin
        start = 1'b1; dst = 16'h9999; src = 16'h0000; bw = ~b; Cin = ~c;
      end else begin
        start = 1'b0;
      end
      @(negedge MCLK);
      lat++;
      got = done;
    end
    start = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; start = 1'b0; bw = 1'b0; src = 16'h0; dst = 16'h0; Cin = 1'b0;
    repeat (2) @(negedge MCLK);
    check("rst.result", result, 16'h0000);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst.busy", {15'd0, busy}, 16'd0);
    check("rst.done", {15'd0, done}, 16'd0);
    check("rst.bad", {15'd0, bad}, 16'd0);
    RSTn = 1'b1;
    @(negedge MCLK);

    run_op(16'h5678, 16'h1234, 1'b1, 1'b0, 1'b0);
    check("w1.busy", {15'd0, busy_seen}, 16'd1);
    check("w1.done", {15'd0, got}, 16'd1);
    check("w1.lat", lat[15:0], 16'd5);
    check("w1.result", result, 16'h4444);
    check_flags("w1", 1'b1, 1'b0, 1'b0);
    @(negedge MCLK);
    check("w1.done_pulse", {15'd0, done}, 16'd0);
    check("w1.hold", result, 16'h4444);

    run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("w2.lat", lat[15:0], 16'd5);
    check("w2.result", result, 16'h9999);
    check_flags("w2", 1'b0, 1'b1, 1'b0);

    run_op(16'h1000, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("w3.result", result, 16'h0998);
    check_flags("w3", 1'b1, 1'b0, 1'b0);

    // Abort in the second RUN cycle: everything returns to reset values at once.
    dst = 16'h5678; src = 16'h1234; Cin = 1'b1; bw = 1'b0; start = 1'b1;
    @(negedge MCLK);
    start = 1'b0;
    @(negedge MCLK);
    RSTn = 1'b0;
    #1;
    check("abort.result", result, 16'h0000);
    check_flags("abort", 1'b0, 1'b0, 1'b0);
    check("abort.busy", {15'd0, busy}, 16'd0);
    check("abort.state", {14'd0, dbg_state}, 16'd0);
    @(negedge MCLK);
    RSTn = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge MCLK);
      if (done === 1'b1) done_seen = 1'b1;
    end
    check("abort.no_done", {15'd0, done_seen}, 16'd0);

    run_op(16'hAB50, 16'hCD51, 1'b1, 1'b1, 1'b0);
    check("b1.lat", lat[15:0], 16'd3);
    check("b1.result", result, 16'h0099);
    check_flags("b1", 1'b0, 1'b1, 1'b0);

    run_op(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1);
    check("eq.lat", lat[15:0], 16'd5);
    check("eq.result", result, 16'h0000);
    check_flags("eq", 1'b1, 1'b0, 1'b1);

    run_op(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("b2.result", result, 16'h0099);
    check_flags("b2", 1'b0, 1'b1, 1'b0);

`ifdef DSUB_INVALID_DIGIT_EN
    exp_bad = 1'b1;
`else
    exp_bad = 1'b0;
`endif
    run_op(16'h00A0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("nbcd.result", result, 16'h00A0);
    check("nbcd.bad", {15'd0, bad}, {15'd0, exp_bad});
    check_flags("nbcd", 1'b1, 1'b0, 1'b0);

    // Held start in byte mode: one accepted operation every 3 cycles.
    run_op(16'h0022, 16'h0011, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 12) begin
      @(negedge MCLK);
      lat++;
      got = done;
    end
    start = 1'b0;
    check("b2b.lat", lat[15:0], 16'd3);
    check("b2b.result", result, 16'h0011);
    check("b2b.bad", {15'd0, bad}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsub_serial.md
# dsub_serial

Nibble-serial decimal (BCD) subtractor for the CPUX execution unit. It computes dst − src − borrow over packed BCD operands in byte or word mode, with borrow taken from the carry flag using the MSP430 convention (C=1 means no borrow). It is the subtract-direction counterpart of the combinational decimal adder. It processes one digit per MCLK under a start/done handshake and produces the C, V, N and Z status flags.

## Interface
Parameters:
- none. Operand width is fixed at 16 bits; byte mode is selected per operation.

Ports:
- `MCLK` input 1: system clock; all state changes on the rising edge.
- `RSTn` input 1: reset, asynchronous, active-low.
- `start` input 1: request a subtraction; sampled only when `busy`=0.
- `bw` input 1: 1 = byte (2 digits, bits [7:0]); 0 = word (4 digits).
- `src` input 16: subtrahend, packed BCD.
- `dst` input 16: minuend, packed BCD.
- `Cin` input 1: carry in; borrow_in = ~Cin.
- `result` output 16: BCD difference, held until the next completion.
- `Cout` output 1: 1 = no final borrow; 0 = borrow out.
- `Vout` output 1: always 0 (undefined by the family guide).
- `Nout` output 1: MSB of the result (bit 15 word, bit 7 byte).
- `Zout` output 1: 1 if the result (active width) is zero.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle completion pulse.
- `bad` output 1: operand contained a non-BCD digit (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE to RUN on `start`=1:
  - latch `src`, `dst`, `bw`;
  - set borrow ← ~`Cin`;
  - set digit index i ← 0;
  - clear the internal accumulator.
- RUN, one digit i per cycle:
  - compute t = dst[i] − src[i] − borrow, 5-bit signed.
  - If t < 0: digit ← t + 10, borrow ← 1. Otherwise: digit ← t, borrow ← 0.
  - Store the digit into accumulator nibble i. Use only the low 4 bits after the +10 correction.
  - Last digit is i=3 (word) or i=1 (byte). After the last digit, go to DONE.
- DONE, for exactly one cycle:
  - `result` ← accumulator, with [15:8] forced to 0 in byte mode;
  - `Cout` ← ~borrow; `Nout` ← MSB of active width; `Zout` ← active width == 0;
  - `done`=1; then return to IDLE.
- `start` while `busy`=1 is ignored; operands and mode are not re-latched.
- `start` during the DONE cycle is accepted, because `busy`=0 in DONE. The next RUN begins on the following edge.
- Input operands may change freely after the accepting edge.

## Timing
- Reset values: state IDLE, `result`=0, `Cout`=0, `Vout`=0, `Nout`=0, `Zout`=0, `busy`=0, `done`=0, `bad`=0, accumulator=0.
- Edge E0 samples `start`=1. `busy`=1 from after E0 through the last RUN cycle.
- Word mode: RUN spans 4 cycles. `done`, `result` and the flags update after edge E4 and `done` is high for that cycle. Latency is 5 cycles from `start` to `done`.
- Byte mode: RUN spans 2 cycles. `done` is high after E2. Latency is 3 cycles.
- `result` and the flags change only on entry to DONE. They are stable between operations.
- Back-to-back: `start` held high gives one accepted operation every 5 cycles (word) or 3 cycles (byte).
- `RSTn` asserted mid-RUN: immediately return to IDLE with the reset values; the partial result is discarded. `done` does not pulse for the aborted operation.

## Configuration
- `DSUB_INVALID_DIGIT_EN` defined:
  - each RUN cycle checks dst[i] > 9 or src[i] > 9;
  - any hit sets a sticky internal flag, cleared on accept;
  - `bad` is updated on DONE together with the other flags and held until the next DONE;
  - the arithmetic is unchanged.
- Undefined: `bad` is tied to 0 and no check logic is built. Non-BCD digits produce the formula result truncated to 4 bits.

## Test plan
- Word, `dst`=0x5678, `src`=0x1234, `Cin`=1 → `result`=0x4444, C=1, N=0, Z=0; `done` high 5 cycles after `start`.
- Word, `dst`=0x0000, `src`=0x0001, `Cin`=1 → `result`=0x9999, C=0, N=1, Z=0.
- Word, `dst`=0x1000, `src`=0x0001, `Cin`=0 → `result`=0x0998, C=1, N=0; borrow ripples through 3 digits.
- Byte, `dst`=0xAB50, `src`=0xCD51, `Cin`=1, `bw`=1 → `result`=0x0099, C=0, N=1; `done` 3 cycles after `start`.
- Equal operands 0x1234/0x1234, `Cin`=1 → `result`=0x0000, Z=1, C=1. Second `start` issued mid-RUN is ignored.
- `RSTn` low in the 2nd RUN cycle → all outputs 0 immediately and no `done` pulse. With the macro defined, `dst`=0x00A0 → `bad`=1 at DONE.
